// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: forward-select codes, per-operand hazard record, MDU tracker states
package hazard_scoreboard_pkg;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_E_ALU = 2'b01;
  localparam logic [1:0] FWD_M_MEM = 2'b10;
  localparam logic [1:0] FWD_M_ALU = 2'b11;
  typedef struct packed {
    logic [1:0] sel;
    logic       stall;
  } opnd_haz_t;
  typedef enum logic {IDLE, BUSY} mdu_state_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/E/M hazard inputs and forward/stall/MDU status outputs
//   slave: hazard controller side, master: pipeline side
interface hazard_scoreboard_if #(parameter int NUM_SRC = 2, REG_AW = 5, STALL_W = 16);
  logic [NUM_SRC*REG_AW-1:0] d_ra;
  logic [NUM_SRC-1:0]        d_need;
  logic                      d_flags_used;
  logic                      d_mdu_issue;
  logic [REG_AW-1:0]         d_mdu_rn;
  logic                      flush;
  logic [REG_AW-1:0]         e_rn;
  logic [REG_AW-1:0]         m_rn;
  logic                      e_wreg;
  logic                      e_m2reg;
  logic                      m_wreg;
  logic                      m_m2reg;
  logic                      e_setcond;
  logic [2*NUM_SRC-1:0]      forward_d;
  logic                      d_available;
  logic                      mdu_busy;
  logic                      mdu_done;
  logic [REG_AW-1:0]         mdu_rn;
  logic [STALL_W-1:0]        stall_cnt;
  modport slave (
    input  d_ra, d_need, d_flags_used, d_mdu_issue, d_mdu_rn, flush,
           e_rn, m_rn, e_wreg, e_m2reg, m_wreg, m_m2reg, e_setcond,
    output forward_d, d_available, mdu_busy, mdu_done, mdu_rn, stall_cnt
  );
  modport master (
    output d_ra, d_need, d_flags_used, d_mdu_issue, d_mdu_rn, flush,
           e_rn, m_rn, e_wreg, e_m2reg, m_wreg, m_m2reg, e_setcond,
    input  forward_d, d_available, mdu_busy, mdu_done, mdu_rn, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_operand_cmp.sv
// hazard_operand_cmp: one decode operand against E/M writers and the pending MDU result
//   in: ra_i/need_i operand, E/M destination+flags, MDU busy/dest; out: haz_o {sel, stall}
module hazard_operand_cmp import hazard_scoreboard_pkg::*; #(parameter int REG_AW = 5) (
  input  logic [REG_AW-1:0] ra_i,
  input  logic              need_i,
  input  logic [REG_AW-1:0] e_rn_i,
  input  logic              e_wreg_i,
  input  logic              e_m2reg_i,
  input  logic [REG_AW-1:0] m_rn_i,
  input  logic              m_wreg_i,
  input  logic              m_m2reg_i,
  input  logic              mdu_busy_i,
  input  logic [REG_AW-1:0] mdu_rn_i,
  output opnd_haz_t         haz_o
);
  logic live, e_hit, m_hit;
  // r0 is hardwired zero, so it never hazards
  assign live  = need_i & |ra_i;
  assign e_hit = live & e_wreg_i & (e_rn_i == ra_i);
  assign m_hit = live & m_wreg_i & (m_rn_i == ra_i);
  assign haz_o.sel = (e_hit & ~e_m2reg_i) ? FWD_E_ALU :
                     m_hit ? (m_m2reg_i ? FWD_M_MEM : FWD_M_ALU) : FWD_RF;
  assign haz_o.stall = (e_hit & e_m2reg_i) | (live & mdu_busy_i & (mdu_rn_i == ra_i));
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode forwarding/stall control plus single in-flight MDU tracker
//   clk/rst: clock, sync active-high reset; bus (slave): pipeline hazard inputs and outputs
module hazard_scoreboard import hazard_scoreboard_pkg::*; #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4,
  parameter int STALL_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  mdu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_AW-1:0] rn_q, rn_d;
  logic [STALL_W-1:0] scnt_q, scnt_d;
  opnd_haz_t [NUM_SRC-1:0] haz;
  logic [2*NUM_SRC-1:0] fwd;
  logic [NUM_SRC-1:0] op_stall;
  logic busy, done, stall, accept;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    hazard_operand_cmp #(.REG_AW(REG_AW)) u_cmp (
      .ra_i(bus.d_ra[i*REG_AW +: REG_AW]),
      .need_i(bus.d_need[i]),
      .e_rn_i(bus.e_rn),
      .e_wreg_i(bus.e_wreg),
      .e_m2reg_i(bus.e_m2reg),
      .m_rn_i(bus.m_rn),
      .m_wreg_i(bus.m_wreg),
      .m_m2reg_i(bus.m_m2reg),
      .mdu_busy_i(busy),
      .mdu_rn_i(rn_q),
      .haz_o(haz[i])
    );
  end
  always_comb begin
    fwd = '0;
    op_stall = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd[2*k +: 2] = haz[k].sel;
      op_stall[k] = haz[k].stall;
    end
  end
  assign busy = (state_q == BUSY);
  assign done = busy & (cnt_q == CNT_W'(1));
  // a new MDU op may enter only in the done cycle of the previous one
  assign stall = |op_stall | (bus.d_flags_used & bus.e_setcond) | (bus.d_mdu_issue & busy & ~done);
  assign accept = bus.d_mdu_issue & ~stall & ~bus.flush;
  always_comb begin
    state_d = (accept | (busy & ~done)) ? BUSY : IDLE;
    cnt_d = accept ? CNT_W'(MDU_LAT) : busy ? cnt_q - CNT_W'(1) : '0;
    rn_d = accept ? bus.d_mdu_rn : rn_q;
    scnt_d = (stall & ~&scnt_q) ? scnt_q + STALL_W'(1) : scnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rn_q <= '0;
      scnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rn_q <= rn_d;
      scnt_q <= scnt_d;
    end
  end
  assign bus.forward_d = fwd;
  assign bus.d_available = ~stall;
  assign bus.mdu_busy = busy;
  assign bus.mdu_done = done;
  assign bus.mdu_rn = rn_q;
  assign bus.stall_cnt = scnt_q;
endmodule
